// File: rtl/pong_match_sequencer_if.sv
// Control/status bundle between the match sequencer and keypad, ball engine and display drivers.
// slave = sequencer side; master = the surrounding logic that drives buttons, ticks and misses.
interface pong_match_sequencer_if;
  logic       start;
  logic       tick_1hz;
  logic       miss1;
  logic       miss2;
  logic       stop;
  logic       serve;
  logic       serve_dir;
  logic [2:0] score1;
  logic [2:0] score2;
  logic [3:0] min;
  logic [3:0] sec1;
  logic [3:0] sec2;
  logic [1:0] winner;
  logic [1:0] state;

  modport master (
    output start, tick_1hz, miss1, miss2,
    input  stop, serve, serve_dir, score1, score2, min, sec1, sec2, winner, state
  );

  modport slave (
    input  start, tick_1hz, miss1, miss2,
    output stop, serve, serve_dir, score1, score2, min, sec1, sec2, winner, state
  );
endinterface

// File: rtl/pong_match_sequencer.sv
// Pong match controller: new game, serve delay, rally, game over; scores and BCD countdown.
// All outputs registered (start press to serve = 2 edges); no backpressure, inputs sampled every cycle.
module pong_match_sequencer #(
  parameter int MATCH_MIN = 3,
  parameter int SERVE_SEC = 2,
  parameter int WIN_SCORE = 7
) (
  input logic                  clk,
  input logic                  rst,
  pong_match_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    SERVE_WAIT = 2'd2,
    OVER       = 2'd3
  } state_t;

  localparam logic [3:0] MIN_INIT   = 4'(MATCH_MIN);
  localparam logic [3:0] SERVE_INIT = 4'(SERVE_SEC);
  localparam logic [2:0] WIN        = 3'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       start_q, start_edge_q;
  logic [2:0] score1_q, score1_d, score2_q, score2_d;
  logic [3:0] min_q, min_d, sec1_q, sec1_d, sec2_q, sec2_d;
  logic [3:0] cnt_q, cnt_d;
  logic       serve_q, serve_d, dir_q, dir_d;
  logic [1:0] winner_q, winner_d;
  logic       expire, single_miss, point_won;

  // start_q resets high so a button held through reset release is not seen as a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b1;
      start_edge_q <= 1'b0;
    end else begin
      start_q      <= bus.start;
      start_edge_q <= bus.start & ~start_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      score1_q <= 3'd0;
      score2_q <= 3'd0;
      min_q    <= MIN_INIT;
      sec1_q   <= 4'd0;
      sec2_q   <= 4'd0;
      cnt_q    <= 4'd0;
      serve_q  <= 1'b0;
      dir_q    <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      min_q    <= min_d;
      sec1_q   <= sec1_d;
      sec2_q   <= sec2_d;
      cnt_q    <= cnt_d;
      serve_q  <= serve_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    min_d       = min_q;
    sec1_d      = sec1_q;
    sec2_d      = sec2_q;
    cnt_d       = cnt_q;
    serve_d     = 1'b0;
    dir_d       = dir_q;
    winner_d    = winner_q;
    expire      = bus.tick_1hz && (min_q == 4'd0) && (sec1_q == 4'd0) && (sec2_q == 4'd1);
    single_miss = bus.miss1 ^ bus.miss2;
    point_won   = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_edge_q) begin
          state_d  = SERVE_WAIT;
          score1_d = 3'd0;
          score2_d = 3'd0;
          min_d    = MIN_INIT;
          sec1_d   = 4'd0;
          sec2_d   = 4'd0;
          cnt_d    = SERVE_INIT;
          serve_d  = 1'b1;
          dir_d    = 1'b0;
          winner_d = 2'b00;
        end
      end

      SERVE_WAIT: begin
        if (bus.tick_1hz) begin
          if (cnt_q <= 4'd1) begin
            state_d = PLAY;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      PLAY: begin
        if (bus.tick_1hz) begin
          if (sec2_q != 4'd0) begin
            sec2_d = sec2_q - 4'd1;
          end else begin
            sec2_d = 4'd9;
            if (sec1_q != 4'd0) begin
              sec1_d = sec1_q - 4'd1;
            end else begin
              sec1_d = 4'd5;
              min_d  = min_q - 4'd1;
            end
          end
        end

        // a simultaneous miss is a let, so neither score moves
        if (bus.miss1 && !bus.miss2 && score2_q < WIN) begin
          score2_d = score2_q + 3'd1;
        end else if (bus.miss2 && !bus.miss1 && score1_q < WIN) begin
          score1_d = score1_q + 3'd1;
        end
        point_won = single_miss && ((score1_d == WIN) || (score2_d == WIN));

        if (point_won || expire) begin
          state_d = OVER;
          if (score1_d > score2_d)      winner_d = 2'b01;
          else if (score2_d > score1_d) winner_d = 2'b10;
          else                          winner_d = 2'b11;
        end else if (bus.miss1 || bus.miss2) begin
          state_d = SERVE_WAIT;
          cnt_d   = SERVE_INIT;
          serve_d = 1'b1;
          if (single_miss) dir_d = bus.miss2;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.stop      = (state_q != PLAY);
  assign bus.serve     = serve_q;
  assign bus.serve_dir = dir_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.min       = min_q;
  assign bus.sec1      = sec1_q;
  assign bus.sec2      = sec2_q;
  assign bus.winner    = winner_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed bench for pong_match_sequencer with MATCH_MIN=1, SERVE_SEC=2, WIN_SCORE=3.
module tb_pong_match_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pong_match_sequencer_if bus ();

  pong_match_sequencer #(
    .MATCH_MIN(1),
    .SERVE_SEC(2),
    .WIN_SCORE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       tick;
    logic       m1;
    logic       m2;
    logic [1:0] st;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [3:0] mn;
    logic [3:0] t;
    logic [3:0] o;
    logic       srv;
    logic       dir;
    logic [1:0] win;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic start, tick, m1, m2,
                              input logic [1:0] st, input logic [2:0] s1, s2,
                              input logic [3:0] mn, t, o,
                              input logic srv, dir, input logic [1:0] win);
    vec_t v;
    v.start = start; v.tick = tick; v.m1 = m1; v.m2 = m2;
    v.st = st; v.s1 = s1; v.s2 = s2; v.mn = mn; v.t = t; v.o = o;
    v.srv = srv; v.dir = dir; v.win = win;
    return v;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input logic [2:0] s1, s2,
                     input logic [3:0] mn, t, o, input logic srv, dir, input logic [1:0] win);
    cmp({nm, ".state"},     int'(bus.state),     int'(st));
    cmp({nm, ".score1"},    int'(bus.score1),    int'(s1));
    cmp({nm, ".score2"},    int'(bus.score2),    int'(s2));
    cmp({nm, ".min"},       int'(bus.min),       int'(mn));
    cmp({nm, ".sec1"},      int'(bus.sec1),      int'(t));
    cmp({nm, ".sec2"},      int'(bus.sec2),      int'(o));
    cmp({nm, ".serve"},     int'(bus.serve),     int'(srv));
    cmp({nm, ".serve_dir"}, int'(bus.serve_dir), int'(dir));
    cmp({nm, ".winner"},    int'(bus.winner),    int'(win));
    cmp({nm, ".stop"},      int'(bus.stop),      (st == 2'd1) ? 0 : 1);
  endtask

  // drive on the falling edge, observe just after the following rising edge
  task automatic step(input logic start, tick, m1, m2);
    @(negedge clk);
    bus.start    = start;
    bus.tick_1hz = tick;
    bus.miss1    = m1;
    bus.miss2    = m2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rem;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = mk(1,0,0,0, 0,0,0,1,0,0, 0,0,0);
    vecs[1]  = mk(1,0,0,0, 0,0,0,1,0,0, 0,0,0);
    vecs[2]  = mk(0,0,0,0, 0,0,0,1,0,0, 0,0,0);
    vecs[3]  = mk(1,0,0,0, 0,0,0,1,0,0, 0,0,0);
    vecs[4]  = mk(1,0,0,0, 2,0,0,1,0,0, 1,0,0);
    vecs[5]  = mk(0,0,0,0, 2,0,0,1,0,0, 0,0,0);
    vecs[6]  = mk(0,1,0,0, 2,0,0,1,0,0, 0,0,0);
    vecs[7]  = mk(0,1,0,0, 1,0,0,1,0,0, 0,0,0);
    vecs[8]  = mk(0,0,1,0, 2,0,1,1,0,0, 1,0,0);
    vecs[9]  = mk(0,0,1,0, 2,0,1,1,0,0, 0,0,0);
    vecs[10] = mk(0,0,1,0, 2,0,1,1,0,0, 0,0,0);
    vecs[11] = mk(0,0,1,0, 2,0,1,1,0,0, 0,0,0);
    vecs[12] = mk(0,0,1,0, 2,0,1,1,0,0, 0,0,0);
    vecs[13] = mk(0,1,0,0, 2,0,1,1,0,0, 0,0,0);
    vecs[14] = mk(0,1,0,0, 1,0,1,1,0,0, 0,0,0);
    vecs[15] = mk(0,0,0,1, 2,1,1,1,0,0, 1,1,0);
    vecs[16] = mk(0,1,0,0, 2,1,1,1,0,0, 0,1,0);
    vecs[17] = mk(0,1,0,0, 1,1,1,1,0,0, 0,1,0);
    vecs[18] = mk(0,0,1,1, 2,1,1,1,0,0, 1,1,0);
    vecs[19] = mk(0,1,0,0, 2,1,1,1,0,0, 0,1,0);
    vecs[20] = mk(0,1,0,0, 1,1,1,1,0,0, 0,1,0);
    vecs[21] = mk(0,0,0,1, 2,2,1,1,0,0, 1,1,0);
    vecs[22] = mk(0,1,0,0, 2,2,1,1,0,0, 0,1,0);
    vecs[23] = mk(0,1,0,0, 1,2,1,1,0,0, 0,1,0);
    vecs[24] = mk(0,0,0,1, 3,3,1,1,0,0, 0,1,1);
    vecs[25] = mk(0,1,1,0, 3,3,1,1,0,0, 0,1,1);
    vecs[26] = mk(1,0,0,0, 3,3,1,1,0,0, 0,1,1);
    vecs[27] = mk(0,0,0,0, 2,0,0,1,0,0, 1,0,0);
    vecs[28] = mk(0,1,0,0, 2,0,0,1,0,0, 0,0,0);
    vecs[29] = mk(0,1,0,0, 1,0,0,1,0,0, 0,0,0);

    rst          = 1'b0;
    bus.start    = 1'b1;
    bus.tick_1hz = 1'b0;
    bus.miss1    = 1'b0;
    bus.miss2    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 0,0,0,1,0,0, 0,0,0);
    @(negedge clk);
    rst = 1'b1;

    // start held through reset release, single point, let, win, restart
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].start, vecs[i].tick, vecs[i].m1, vecs[i].m2);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].s1, vecs[i].s2,
          vecs[i].mn, vecs[i].t, vecs[i].o, vecs[i].srv, vecs[i].dir, vecs[i].win);
    end

    // full minute countdown at 0-0 ends in a tie
    for (int i = 1; i <= 60; i++) begin
      step(0, 1, 0, 0);
      rem = 60 - i;
      chk($sformatf("timer%0d", i), (i == 60) ? 2'd3 : 2'd1, 0, 0,
          4'(rem / 60), 4'((rem % 60) / 10), 4'(rem % 10), 0, 0, (i == 60) ? 2'd3 : 2'd0);
    end

    step(1, 0, 0, 0);
    chk("restart1_edge", 3,0,0,0,0,0, 0,0,3);
    step(0, 0, 0, 0);
    chk("restart1", 2,0,0,1,0,0, 1,0,0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("restart1_play", 1,0,0,1,0,0, 0,0,0);

    for (int i = 1; i <= 59; i++) begin
      step(0, 1, 0, 0);
      rem = 60 - i;
      if (i == 1 || i == 10 || i == 59)
        chk($sformatf("run%0d", i), 1, 0, 0,
            4'(rem / 60), 4'((rem % 60) / 10), 4'(rem % 10), 0, 0, 0);
    end

    // last tick and a miss together: point counts, match ends, no serve
    step(0, 1, 1, 0);
    chk("collide", 3,0,1,0,0,0, 0,0,2);
    step(0, 0, 0, 0);
    chk("collide_hold", 3,0,1,0,0,0, 0,0,2);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("restart2", 2,0,0,1,0,0, 1,0,0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("play_tick", 1,0,0,0,5,9, 0,0,0);
    step(0, 0, 1, 0);
    chk("pre_reset", 2,0,1,0,5,9, 1,0,0);

    // asynchronous reset between clock edges
    @(negedge clk);
    bus.miss1 = 1'b0;
    bus.start = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async_reset", 0,0,0,1,0,0, 0,0,0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("post_reset_held", 0,0,0,1,0,0, 0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_match_sequencer.md
# pong_match_sequencer

Match-level controller for the Pong datapath. Sequences new game, serve delay, rally play and game over. Keeps both 3-bit scores and the BCD match countdown, and tells the ball/paddle engine when to freeze and when to re-serve. Sits between the keypad/start button, the ball engine's miss flags, and the score dot-matrix and seven-segment display drivers.

## Interface
- `MATCH_MIN`, default 3: match length in minutes, range 1–9; loaded as MATCH_MIN:00.
- `SERVE_SEC`, default 2: serve delay in 1 Hz ticks, range 1–15.
- `WIN_SCORE`, default 7: score that ends the match, range 1–7.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous and active-low.
- `start` in 1: start button level, already synchronised; the block detects its rising edge internally.
- `tick_1hz` in 1: one-`clk`-cycle enable pulse at 1 Hz.
- `miss1` in 1: player 1 failed to return the ball; level.
- `miss2` in 1: player 2 failed to return the ball; level.
- `stop` out 1: freezes the ball and paddles; 1 in every state except PLAY.
- `serve` out 1: one-cycle pulse telling the ball engine to re-centre the ball.
- `serve_dir` out 1: launch direction sampled with `serve`; 0 = toward player 1, 1 = toward player 2.
- `score1` out 3: player 1 score.
- `score2` out 3: player 2 score.
- `min` out 4: remaining time, minutes digit (BCD).
- `sec1` out 4: remaining time, seconds-tens digit (BCD).
- `sec2` out 4: remaining time, seconds-ones digit (BCD).
- `winner` out 2: 00 = none, 01 = player 1, 10 = player 2, 11 = tie; valid in OVER only.
- `state` out 2: 0 IDLE, 1 PLAY, 2 SERVE_WAIT, 3 OVER.

## Operation
- **Reset values:** state IDLE; scores 0; timer MATCH_MIN:0:0; serve 0; serve_dir 0; winner 00; stop 1; serve counter 0; start edge register 0.
- **Start edge:** `start_edge = start & ~start_q`, where `start_q` is `start` registered.
- **IDLE:**
  - On `start_edge`: clear scores, reload the timer, load the serve counter with SERVE_SEC, pulse `serve` with serve_dir 0, go to SERVE_WAIT.
  - `tick_1hz`, `miss1` and `miss2` are ignored.
- **SERVE_WAIT:**
  - On `tick_1hz`, decrement the serve counter.
  - A tick that arrives while the counter is 1 moves the block to PLAY.
  - The match timer is frozen and misses are ignored.
- **PLAY:** `stop` = 0. Each cycle, in this priority order:
  - **Simultaneous miss** (`miss1` & `miss2`): no score change. Re-serve toward the same `serve_dir`: pulse `serve`, reload the counter, go to SERVE_WAIT.
  - **Player 1 missed** (`miss1` only): score2 + 1.
  - **Player 2 missed** (`miss2` only): score1 + 1.
  - **After a single miss:** if the new score equals WIN_SCORE, go to OVER. Otherwise pulse `serve` with serve_dir toward the player who conceded (0 after `miss1`, 1 after `miss2`), reload the counter, go to SERVE_WAIT.
  - **Tick:** on `tick_1hz`, decrement the timer in BCD.
    - sec2 0 becomes 9 and borrows from sec1.
    - sec1 0 becomes 5 and borrows from min.
  - **Expiry:** a tick that takes the timer from 0:0:1 to 0:0:0 moves the block to OVER.
  - **Miss and expiry in the same cycle:** apply the score first, then go to OVER; no `serve` pulse.
- **Scores:** never exceed WIN_SCORE; the 3-bit arithmetic never wraps.
- **OVER:**
  - `winner` is latched on entry from the final scores.
  - `start_edge` behaves as in IDLE: starts a new match, clears winner, goes directly to SERVE_WAIT.
  - Misses and ticks are ignored; timer and scores hold.
- **Miss flags:** levels are sampled only in PLAY. Because PLAY is left in the cycle after a miss, a multi-cycle miss level scores exactly once.

## Timing
- All outputs are registered. An event sampled at edge N appears on outputs after edge N.
- `serve` is high for exactly one cycle: the first cycle in SERVE_WAIT. `serve_dir` is stable during that cycle and holds afterwards.
- `stop` is decoded from the registered state: 0 from the first PLAY cycle; 1 from the cycle after a miss or expiry.
- Start press to first `serve`: 2 edges (the edge-detect register plus the state register).
- Serve delay: SERVE_SEC ticks; 1–2 s wall time depending on tick phase.
- Reset asserted mid-match: all registers return to reset values immediately, asynchronously. After deassertion the block waits in IDLE for a fresh `start` edge, even if `start` is held high.

## Test plan
All scenarios use MATCH_MIN=1, SERVE_SEC=2, WIN_SCORE=3.
- **Reset and start:** reset, hold `start` high through deassertion. Required: no transition. Then drop and raise `start`: `serve` pulses once, serve_dir=0, state=2, timer 1:0:0. After 2 ticks, state=1 and stop=0.
- **Single point:** in PLAY, hold `miss1` for 5 cycles. Required: score2=1 and score1=0 exactly, one `serve` pulse with serve_dir=0, state=2.
- **Simultaneous miss:** assert `miss1` and `miss2` together. Required: scores unchanged, `serve` pulses, serve_dir unchanged.
- **Win:** drive 3 `miss2` events with serve waits between them. Required: score1=3, state=3, winner=01, no third `serve` pulse, stop=1.
- **Timer:** 60 ticks in PLAY, no misses. Required: sequence 1:0:0, 0:5:9 … 0:0:1, 0:0:0; state=3 at 0:0:0; winner=11 at 0–0.
- **Expiry collision and restart:** `miss1` in the same cycle as the final tick, scores 0–0. Required: score2=1, state=3, winner=10. Then a `start` edge: scores 0, timer 1:0:0, state=2.
